branch_target_buffer: RTL

//  Direct-mapped branch target buffer plus direction predictor.

---
 rtl/branch_target_buffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with direction predictor
//
// Purpose:
//   Looks up the fetch PC combinationally and supplies a taken prediction and
//   target for the next-PC selector. Trained from EX with resolved conditional
//   branches. Also counts resolved and mispredicted branches.
//
// Configuration macro: BTB_2BIT_COUNTER_EN
//   defined   - per-entry 2-bit saturating counter, taken_bit = cnt[1]
//   undefined - any hit predicts taken; a not-taken hit evicts the entry
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   PCF                 fetch PC to look up
//   pred_taken          predict taken for PCF (combinational)
//   pred_target         predicted target (0 unless pred_taken)
//   upd_valid           EX holds a resolved conditional branch
//   upd_pc              PC of the resolving branch
//   upd_taken           resolved direction
//   upd_target          resolved target
//   upd_pred_taken      prediction carried down the pipe
//   upd_pred_target     predicted target carried down the pipe
//   mispredict          combinational mispredict flag for the update
//   br_count            resolved branch count (wraps)
//   mispred_count       mispredicted branch count (wraps)

module branch_target_buffer #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
`ifdef BTB_2BIT_COUNTER_EN
    logic [1:0]       cnt_q    [ENTRIES];
`endif

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic             rd_taken_bit;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;

    // Byte offset bits never participate in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], upd_pc[1:0]};

    assign rd_idx = PCF[IDX_W+1:2];
    assign rd_tag = PCF[31:IDX_W+2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[31:IDX_W+2];

    always_comb begin
        rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
`ifdef BTB_2BIT_COUNTER_EN
        rd_taken_bit = cnt_q[rd_idx][1];
`else
        rd_taken_bit = 1'b1;
`endif
        pred_taken  = rd_hit && rd_taken_bit;
        pred_target = pred_taken ? target_q[rd_idx] : 32'd0;
    end

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    // Table in flops so reset can clear every entry at once. Lookups read the
    // registered state, so a same-cycle update is only visible next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
`ifdef BTB_2BIT_COUNTER_EN
                cnt_q[i]    <= 2'b01;
`endif
            end
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else if (upd_valid) begin
            br_count <= br_count + 32'd1;
            if (mispredict) begin
                mispred_count <= mispred_count + 32'd1;
            end
            if (wr_hit) begin
                if (upd_taken) begin
                    target_q[wr_idx] <= upd_target;
`ifdef BTB_2BIT_COUNTER_EN
                    if (cnt_q[wr_idx] != 2'b11) begin
                        cnt_q[wr_idx] <= cnt_q[wr_idx] + 2'd1;
                    end
`endif
                end else begin
`ifdef BTB_2BIT_COUNTER_EN
                    if (cnt_q[wr_idx] != 2'b00) begin
                        cnt_q[wr_idx] <= cnt_q[wr_idx] - 2'd1;
                    end
`else
                    valid_q[wr_idx] <= 1'b0;
`endif
                end
            end else if (upd_taken) begin
                // Allocate only on taken; start weakly taken.
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= upd_target;
`ifdef BTB_2BIT_COUNTER_EN
                cnt_q[wr_idx]    <= 2'b10;
`endif
            end
        end
    end

endmodule
